cache_fill_fsm: RTL
===================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter BLOCK_WORDS, default 8, gives the 16-bit words per cache block; it SHALL be a power of two between 2 and 16.
REQ-002 Parameter ADDR_W, default 16, gives the byte-address width.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset; it SHALL be asynchronous and active-low.
REQ-005 Port miss_detected, input, 1: the cache reports a miss this cycle.
REQ-006 Port miss_address, input, ADDR_W: byte address of the missing access.
REQ-007 Port memory_data_valid, input, 1: the multi-cycle memory returns one word this cycle.
REQ-008 Port fsm_busy, output, 1: a fill is in progress and the pipeline must stall.
REQ-009 Port mem_read_en, output, 1: issue a read request to memory this cycle.
REQ-010 Port memory_address, output, ADDR_W: byte address of the current read request.
REQ-011 Port write_data_array, output, 1: write the returned word into the cache data array.
REQ-012 Port data_word_sel, output, log2(BLOCK_WORDS): word slot within the block for write_data_array.
REQ-013 Port write_tag_array, output, 1: write the tag and valid bit for the filled block.
REQ-014 Port fill_count, output, 16: number of completed fills (see Configuration).

Function
REQ-015 The FSM SHALL have two states, IDLE and FILL, encoded in flops.
- IDLE to FILL: on miss_detected=1.
- FILL to IDLE: on the edge after the BLOCK_WORDS-th memory_data_valid.
REQ-016 On IDLE→FILL the block SHALL latch base = miss_address with its low log2(2*BLOCK_WORDS) bits cleared, and clear the issue count and return count.
REQ-017 fsm_busy SHALL equal (state==FILL); it is registered, so it rises the cycle after miss_detected is sampled.
REQ-018 In FILL, while issue count < BLOCK_WORDS, the block SHALL:
- drive mem_read_en=1 and memory_address = base + 2*issue count;
- increment the issue count by one each cycle.
REQ-019 Otherwise mem_read_en SHALL be 0 and memory_address SHALL hold base.
REQ-020 In FILL, on each memory_data_valid=1 the block SHALL:
- drive write_data_array=1 combinationally in that cycle;
- drive data_word_sel = return count;
- increment the return count by one.
REQ-021 write_tag_array SHALL pulse for one cycle, coincident with the final (BLOCK_WORDS-th) write_data_array.
REQ-022 Latency is set by memory: with a 4-cycle memory and BLOCK_WORDS=8, counting the miss-sample edge as cycle 0:
- requests in cycles 1–8;
- writes in cycles 5–12;
- tag write in cycle 12;
- fsm_busy low from cycle 13.
REQ-023 miss_detected SHALL be ignored in FILL; memory_data_valid SHALL be ignored in IDLE, and no write strobe is produced.
REQ-024 If miss_detected is asserted in the same cycle that FILL completes, it SHALL NOT start a new fill that cycle; it is sampled again in IDLE.
REQ-025 Counters SHALL NOT wrap: issue count saturates at BLOCK_WORDS, and return count never exceeds BLOCK_WORDS-1 on data_word_sel.
REQ-026 Address arithmetic SHALL be modulo 2^ADDR_W.

Reset
REQ-027 While rst_n=0, all outputs SHALL be held at their reset values:
- state=IDLE, base=0, both counters=0;
- fsm_busy=0, mem_read_en=0, memory_address=0;
- write_data_array=0, write_tag_array=0, data_word_sel=0, fill_count=0.
REQ-028 A reset mid-fill SHALL abandon the fill with no tag write; after rst_n rises the block SHALL sit in IDLE.

Configuration
REQ-029 With macro CACHE_FILL_STATS_EN defined, fill_count SHALL increment (saturating at 16'hFFFF) on each write_tag_array pulse.
REQ-030 Without CACHE_FILL_STATS_EN, fill_count SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-031 Miss at 16'h1236 with 4-cycle memory: requests go to 16'h1230..16'h123E in order, data_word_sel steps 0..7, write_tag_array pulses once in cycle 12, fsm_busy is high in cycles 1–12.
REQ-032 memory_data_valid pulsed in IDLE: write_data_array stays 0 and the state stays IDLE.
REQ-033 miss_detected held high throughout a fill: exactly one fill occurs; a second fill starts only after fsm_busy falls, provided miss_detected is still high.
REQ-034 rst_n driven low after 3 returned words, then released: all outputs are 0 and the next miss restarts with data_word_sel=0.
REQ-035 Miss at 16'hFFF2: the base is 16'hFFF0, the last request is 16'hFFFE, and no address overflow beyond 16'hFFFE occurs.
REQ-036 With CACHE_FILL_STATS_EN, three back-to-back fills give fill_count=3; without the macro, fill_count stays 0.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache block fill sequencer: one miss issues BLOCK_WORDS reads, writes returns, then tags.
// Optional fill statistics counter enabled by defining CACHE_FILL_STATS_EN.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  input  logic                           memory_data_valid,
  output logic                           fsm_busy,
  output logic                           mem_read_en,
  output logic [ADDR_W-1:0]              memory_address,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] data_word_sel,
  output logic                           write_tag_array,
  output logic [15:0]                    fill_count
);

  localparam int SelW = $clog2(BLOCK_WORDS);
  localparam int CntW = SelW + 1;
  localparam logic [CntW-1:0] NumWords = CntW'(BLOCK_WORDS);
  localparam logic [CntW-1:0] LastWord = CntW'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] OffMask =
    ADDR_W'(2 * BLOCK_WORDS - 1);

  typedef enum logic {
    Idle = 1'b0,
    Fill = 1'b1
  } state_t;

  state_t            stateQ, stateD;
  logic [ADDR_W-1:0] baseQ;
  logic [CntW-1:0]   issueCnt;
  logic [CntW-1:0]   retCnt;
  logic              issuing;
  logic              startFill;

  always_comb begin
    stateD           = stateQ;
    issuing          = 1'b0;
    startFill        = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = baseQ;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    data_word_sel    = '0;
    unique case (stateQ)
      Idle: begin
        if (miss_detected) begin
          startFill = 1'b1;
          stateD    = Fill;
        end
      end
      Fill: begin
        if (issueCnt < NumWords) begin
          issuing        = 1'b1;
          mem_read_en    = 1'b1;
          memory_address = baseQ + (ADDR_W'(issueCnt) << 1);
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_word_sel    = retCnt[SelW-1:0];
          // Tag goes in with the last word so the block becomes valid atomically.
          if (retCnt == LastWord) begin
            write_tag_array = 1'b1;
            stateD          = Idle;
          end
        end
      end
      default: stateD = Idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= Idle;
      baseQ    <= '0;
      issueCnt <= '0;
      retCnt   <= '0;
    end else begin
      stateQ <= stateD;
      if (startFill) begin
        baseQ    <= miss_address & ~OffMask;
        issueCnt <= '0;
        retCnt   <= '0;
      end else begin
        if (issuing)          issueCnt <= issueCnt + 1'b1;
        if (write_data_array) retCnt   <= retCnt + 1'b1;
      end
    end
  end

  assign fsm_busy = (stateQ == Fill);

`ifdef CACHE_FILL_STATS_EN
  logic [15:0] fillCntQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fillCntQ <= '0;
    end else if (write_tag_array && fillCntQ != 16'hFFFF) begin
      fillCntQ <= fillCntQ + 16'd1;
    end
  end

  assign fill_count = fillCntQ;
`else
  assign fill_count = 16'd0;
`endif

endmodule
